hdmi_driver: RTL and testbench

HDMI_DRIVER -- requirements
Module: hdmi_driver

---
 rtl/hdmi_driver.sv | 172 +++++++++++++++++
 tb/tb_hdmi_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_driver.sv
// 640x480-style DVI/HDMI colour-bar source: pixel timing, TMDS 8b/10b encoding
// and 10:1 LSB-first serialisation, all running on the bit clock.
module hdmi_driver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk_in,
  input  logic       rst_n,
  output logic [2:0] TMDSp,
  output logic [2:0] TMDSn,
  output logic       TMDSp_clock,
  output logic       TMDSn_clock
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = 6;

  logic [3:0]          bcnt;
  logic [HW-1:0]       hcnt;
  logic [VW-1:0]       vcnt;
  logic                strobe_c;
  logic                de_c;
  logic                hsync_c;
  logic                vsync_c;
  logic [2:0]          bar_c;
  logic [23:0]         rgb_c;
  logic [9:0]          word_c     [3];
  logic signed [DW-1:0] disp_nxt_c [3];
  logic signed [DW-1:0] disp_q     [3];
  logic [9:0]          enc_q      [3];
  logic [9:0]          sr_q       [3];
  logic [2:0]          tmdsn_q;
  logic [9:0]          clk_sr_q;
  logic                clkn_q;

  // DVI control tokens, indexed {c1,c0}
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  // DVI 8b/10b data encoding; returns {next disparity, 10-bit word}
  function automatic logic [DW+9:0] tmds_encode(input logic [7:0] d,
                                                 input logic signed [DW-1:0] disp);
    logic [3:0]           n1d;
    logic [3:0]           n1q;
    logic                 xnor_sel;
    logic [8:0]           qm;
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] dn;
    logic [9:0]           q;
    n1d      = 4'($countones(d));
    xnor_sel = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = xnor_sel ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~xnor_sel;
    n1q   = 4'($countones(qm[7:0]));
    diff  = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    if ((disp == 0) || (diff == 0)) begin
      q  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      dn = qm[8] ? (disp + diff) : (disp - diff);
    end else if (((disp > 0) && (diff > 0)) || ((disp < 0) && (diff < 0))) begin
      q  = {1'b1, qm[8], ~qm[7:0]};
      dn = disp + (qm[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      q  = {1'b0, qm[8], qm[7:0]};
      dn = disp - (qm[8] ? 6'sd0 : 6'sd2) + diff;
    end
    return {dn, q};
  endfunction

  assign strobe_c = (bcnt == 4'd9);
  assign de_c     = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
  assign hsync_c  = !((32'(hcnt) >= H_ACTIVE + H_FP) && (32'(hcnt) < H_ACTIVE + H_FP + H_SYNC));
  assign vsync_c  = !((32'(vcnt) >= V_ACTIVE + V_FP) && (32'(vcnt) < V_ACTIVE + V_FP + V_SYNC));
  assign bar_c    = 3'(32'(hcnt) / 32'd80);

  // Colour bars as {R,G,B}
  always_comb begin
    rgb_c = 24'h000000;
    case (bar_c)
      3'd0:    rgb_c = 24'hFFFFFF;
      3'd1:    rgb_c = 24'hFFFF00;
      3'd2:    rgb_c = 24'h00FFFF;
      3'd3:    rgb_c = 24'h00FF00;
      3'd4:    rgb_c = 24'hFF00FF;
      3'd5:    rgb_c = 24'hFF0000;
      3'd6:    rgb_c = 24'h0000FF;
      default: rgb_c = 24'h000000;
    endcase
  end

  // Channel 0 carries c0 = hsync, c1 = vsync during blanking; blanking clears disparity
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      word_c[i]     = '0;
      disp_nxt_c[i] = '0;
    end
    if (de_c) begin
      for (int i = 0; i < 3; i++) begin
        {disp_nxt_c[i], word_c[i]} = tmds_encode(rgb_c[8*i +: 8], disp_q[i]);
      end
    end else begin
      word_c[0] = ctrl_token({vsync_c, hsync_c});
      word_c[1] = ctrl_token(2'b00);
      word_c[2] = ctrl_token(2'b00);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      bcnt     <= '0;
      hcnt     <= '0;
      vcnt     <= '0;
      tmdsn_q  <= 3'b111;
      clk_sr_q <= '0;
      clkn_q   <= 1'b1;
      for (int i = 0; i < 3; i++) begin
        disp_q[i] <= '0;
        enc_q[i]  <= '0;
        sr_q[i]   <= '0;
      end
    end else begin
      bcnt <= strobe_c ? 4'd0 : bcnt + 4'd1;
      if (strobe_c) begin
        if (hcnt == HW'(H_TOTAL - 1)) begin
          hcnt <= '0;
          vcnt <= (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
      // Negative rails track the next value of the positive rails' LSB
      for (int i = 0; i < 3; i++) begin
        if (strobe_c) begin
          disp_q[i] <= disp_nxt_c[i];
          enc_q[i]  <= word_c[i];
          sr_q[i]   <= enc_q[i];
        end else begin
          sr_q[i]   <= {1'b0, sr_q[i][9:1]};
        end
        tmdsn_q[i] <= ~(strobe_c ? enc_q[i][0] : sr_q[i][1]);
      end
      clk_sr_q <= strobe_c ? 10'b0000011111 : {1'b0, clk_sr_q[9:1]};
      clkn_q   <= ~(strobe_c ? 1'b1 : clk_sr_q[1]);
    end
  end

  assign TMDSp       = {sr_q[2][0], sr_q[1][0], sr_q[0][0]};
  assign TMDSn       = tmdsn_q;
  assign TMDSp_clock = clk_sr_q[0];
  assign TMDSn_clock = clkn_q;

endmodule

// File: tb/tb_hdmi_driver.sv
// Bench for hdmi_driver: random reset points, per-word comparison against a
// pixel-level model of timing, colour bars and TMDS encoding.
module tb_hdmi_driver;

  localparam int unsigned HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int unsigned VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] TMDSp;
  logic [2:0] TMDSn;
  logic       TMDSp_clock;
  logic       TMDSn_clock;

  hdmi_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .TMDSp       (TMDSp),
    .TMDSn       (TMDSn),
    .TMDSp_clock (TMDSp_clock),
    .TMDSn_clock (TMDSn_clock)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int h);
    logic [23:0] c;
    case (h / 80)
      0: c = 24'hFFFFFF;
      1: c = 24'hFFFF00;
      2: c = 24'h00FFFF;
      3: c = 24'h00FF00;
      4: c = 24'hFF00FF;
      5: c = 24'hFF0000;
      6: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [9:0] ctrl_word(input logic c1, input logic c0);
    logic [9:0] t;
    case ({c1, c0})
      2'b00: t = 10'b1101010100;
      2'b01: t = 10'b0010101011;
      2'b10: t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

  task automatic tmds_model(input logic [7:0] d, input int disp_in,
                            output logic [9:0] q, output int disp_out);
    int n1;
    int ones;
    int bal;
    logic use_xnor;
    logic [8:0] qm;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !use_xnor;
    ones = $countones(qm[7:0]);
    bal  = ones - (8 - ones);
    if (disp_in == 0 || bal == 0) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disp_out = qm[8] ? disp_in + bal : disp_in - bal;
    end else if ((disp_in > 0 && bal > 0) || (disp_in < 0 && bal < 0)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp_out = disp_in + (qm[8] ? 2 : 0) - bal;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp_out = disp_in - (qm[8] ? 0 : 2) + bal;
    end
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] v;
    logic [7:0] d;
    v = q[9] ? ~q[7:0] : q[7:0];
    d = '0;
    d[0] = v[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    return d;
  endfunction

  int         k;
  int         mdisp [3];
  logic [9:0] exp_w [3];
  logic [9:0] got_w [3];
  logic [9:0] got_clk;
  logic       n_ok;
  int         pix_h, pix_v, slot;
  logic       pix_active;
  int         line_cnt;

  // Expected words for the slot that begins now (slot p carries pixel p-1)
  task automatic prepare(input int p);
    int n;
    logic [23:0] rgb;
    slot = p;
    pix_active = 1'b0;
    if (p == 0) begin
      for (int i = 0; i < 3; i++) exp_w[i] = '0;
      pix_h = -1;
      pix_v = -1;
    end else begin
      n = p - 1;
      pix_h = n % HT;
      pix_v = (n / HT) % VT;
      if (pix_h < HA && pix_v < VA) begin
        pix_active = 1'b1;
        rgb = bar_rgb(pix_h);
        for (int i = 0; i < 3; i++) tmds_model(rgb[8*i +: 8], mdisp[i], exp_w[i], mdisp[i]);
      end else begin
        exp_w[0] = ctrl_word(!(pix_v >= VA + VF && pix_v < VA + VF + VS),
                             !(pix_h >= HA + HF && pix_h < HA + HF + HS));
        exp_w[1] = ctrl_word(1'b0, 1'b0);
        exp_w[2] = ctrl_word(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) mdisp[i] = 0;
      end
    end
    n_ok = 1'b1;
  endtask

  task automatic compare_word();
    check_eq("ch0_word", 32'(got_w[0]), 32'(exp_w[0]));
    check_eq("ch1_word", 32'(got_w[1]), 32'(exp_w[1]));
    check_eq("ch2_word", 32'(got_w[2]), 32'(exp_w[2]));
    check_eq("clk_word", 32'(got_clk), 32'(10'b0000011111));
    check_eq("n_is_not_p", 32'(n_ok), 32'(1));
    if (pix_active)
      check_eq("decoded_rgb", {8'h0, tmds_decode(got_w[2]), tmds_decode(got_w[1]), tmds_decode(got_w[0])},
               {8'h0, bar_rgb(pix_h)});
    if (slot > 0) begin
      if (got_w[0] == 10'b0101010100) line_cnt++;
      if (pix_h == int'(HT) - 1) begin
        check_eq("hsync_words_per_line", 32'(line_cnt),
                 (pix_v >= VA + VF && pix_v < VA + VF + VS) ? 32'd0 : 32'(HS));
        line_cnt = 0;
      end
    end
  endtask

  // Sampled on the falling edge; rst_n here is the level seen at the preceding rising edge
  task automatic sample();
    int b;
    if (!rst_n) begin
      k = 0;
      line_cnt = 0;
      for (int i = 0; i < 3; i++) mdisp[i] = 0;
      check_eq("reset_levels", {24'h0, TMDSp, TMDSn, TMDSp_clock, TMDSn_clock}, 32'h1D);
    end else begin
      k++;
      if (k < 10) begin
        check_eq("post_reset_levels", {24'h0, TMDSp, TMDSn, TMDSp_clock, TMDSn_clock}, 32'h1D);
      end else begin
        b = (k - 10) % 10;
        if (b == 0) prepare((k - 10) / 10);
        for (int i = 0; i < 3; i++) got_w[i][b] = TMDSp[i];
        got_clk[b] = TMDSp_clock;
        if (TMDSn !== ~TMDSp || TMDSn_clock !== ~TMDSp_clock) n_ok = 1'b0;
        if (b == 9) compare_word();
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_in);
      @(negedge clk_in);
      sample();
    end
  endtask

  initial begin
    int delta;
    k = 0;
    line_cnt = 0;
    rst_n = 1'b0;
    run(20);
    rst_n = 1'b1;
    run(int'(HT * VT * 10) + 500);

    // Reset part-way into a line near hcnt 300
    delta = ((300 + int'($urandom_range(0, 40)) - ((k / 10) % int'(HT)) + int'(HT)) % int'(HT)) * 10
            + int'($urandom_range(0, 9));
    run(delta);
    rst_n = 1'b0;
    run(int'($urandom_range(1, 20)));
    rst_n = 1'b1;
    run(int'(2 * HT * 10) + 200);

    for (int r = 0; r < 3; r++) begin
      run(int'($urandom_range(100, 4000)));
      rst_n = 1'b0;
      run(int'($urandom_range(1, 5)));
      rst_n = 1'b1;
    end
    run(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
